sr_bcd_step_driver: RTL
=======================

# sr_bcd_step_driver

Drives a bank of four external SR flip-flops so they step through an even or odd BCD count sequence. Each count step computes the target value, derives the S/R excitation per bit, pulses it for one cycle, and checks the flip-flop outputs fed back to the block. The block sits beside the even/odd BCD counter's SR storage bits and owns their sequencing and consistency checking.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits; only 4 is supported (BCD).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  request one count step; sampled in IDLE only.
- `mode`  in  1  0 = even sequence 0,2,4,6,8; 1 = odd sequence 1,3,5,7,9. Sampled at step start.
- `load`  in  1  request a parallel load of `load_val`; sampled in IDLE only; wins over `en`.
- `load_val`  in  4  value to load.
- `q_fb`  in  4  Q outputs of the external SR flip-flops.
- `clr_err`  in  1  clears `mismatch`.
- `s`  out  4  set excitation to the external flip-flops.
- `r`  out  4  reset excitation to the external flip-flops.
- `count`  out  4  committed count value.
- `busy`  out  1  high in STEP and VERIFY.
- `done`  out  1  one-cycle pulse on VERIFY exit.
- `tc`  out  1  terminal count: `count`==8 with mode 0, or `count`==9 with mode 1.
- `mismatch`  out  1  sticky flag: feedback did not match the target.

## Operation
- FSM states:
  - IDLE: if `load`, then target = `load_val`. Values above 9 are replaced by the mode base (0 even, 1 odd). Else if `en`, target = next(`count`). Either path goes to STEP.
  - STEP: lasts exactly one cycle with `s`/`r` driven, then goes to VERIFY.
  - VERIFY: lasts one cycle.
    - `count` takes the target value.
    - If `q_fb` != target, set `mismatch`.
    - Pulse `done`, then return to IDLE.
- next(c):
  - Even mode: 0→2→4→6→8→0.
  - Odd mode: 1→3→5→7→9→1.
  - If c has the wrong parity for the mode, or c > 9, next = mode base (resync).
- Excitation per bit i, with cur = `count`:
  - `s[i]` = ~cur[i] & tgt[i]
  - `r[i]` = cur[i] & ~tgt[i]
  - For hold cases (0→0, 1→1), both are 0.
- `s[i]` and `r[i]` are never both 1. This invariant holds in every cycle.
- `s` and `r` are 0 in every state except STEP.
- Requests made while `busy` are dropped, not queued.
- `mismatch`: a new set wins over a simultaneous `clr_err`. `clr_err` alone clears it on the next edge.

## Timing
- Reset values: state IDLE, `count`=0, target=0, `s`=0, `r`=0, `busy`=0, `done`=0, `tc`=0, `mismatch`=0.
- All outputs are registered.
- Step latency: request seen at edge N.
  - `s`/`r`/`busy` are valid after edge N.
  - VERIFY is entered at edge N+1, and `s`/`r` are 0 after it.
  - At edge N+2: `count` updates, `mismatch` may set, `done` is high for one cycle, `busy` falls.
- Throughput: one step per 3 cycles. `en` held high gives steps starting every third edge.
- `q_fb` is sampled at the VERIFY→IDLE edge. The external flip-flops must settle within the one cycle following STEP.
- `tc` is registered alongside `count`. It uses the mode latched at the last step start.
- `rst` mid-step: the next edge forces IDLE, `s`=`r`=0, and `count`=0. No `done` pulse, no `mismatch` update.

## Structure
- Package `sr_bcd_pkg`:
  - state enum {IDLE, STEP, VERIFY};
  - constants EVEN_BASE=4'd0, ODD_BASE=4'd1, EVEN_TC=4'd8, ODD_TC=4'd9, BCD_MAX=4'd9;
  - function `next_eo(c, mode)`.
- One combinational sub-module `sr_excite`: (cur[3:0], tgt[3:0]) → (s[3:0], r[3:0]). It is reusable by any SR-based counter block.

## Test plan
- Reset, then mode=0, `en` held high, `q_fb` mirroring the ideal flip-flop response:
  - `count` goes 0,2,4,6,8,0;
  - first step drives s=0010, r=0000;
  - the 8→0 step drives s=0000, r=1000;
  - `tc`=1 only at 8;
  - `mismatch` stays 0.
- `count`=4 with mode=1, `en` → target 1 (resync); s=0001, r=0100; then 3,5,7,9,1.
- IDLE with `load`=1, `en`=1, `load_val`=7:
  - load wins, `count`=7 after 3 cycles, s=0111, r=0000.
  - Separately, `load_val`=12 with mode=0 → `count`=0.
- `q_fb` forced to 0000 during a 0→2 step → `mismatch`=1 and `count`=2.
  - `clr_err` alone clears it.
  - `clr_err` in the same cycle as a new mismatch leaves it at 1.
- `rst` asserted in STEP:
  - next edge gives s=r=0, `busy`=0, `count`=0, no `done` pulse.
  - An `en` pulse during `busy` is ignored: the step count is unchanged.
- Assertion over all scenarios: (`s` & `r`)==0 every cycle, and `s`|`r` is nonzero only in STEP.

Source files
------------

// File: rtl/sr_bcd_pkg.sv
// rtl/sr_bcd_pkg.sv - shared states, constants and next-count helper for the SR BCD step driver
package sr_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    VERIFY = 2'd2
  } state_e;

  localparam logic [3:0] EVEN_BASE = 4'd0;
  localparam logic [3:0] ODD_BASE  = 4'd1;
  localparam logic [3:0] EVEN_TC   = 4'd8;
  localparam logic [3:0] ODD_TC    = 4'd9;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  function automatic logic [3:0] mode_base(input logic mode);
    return mode ? ODD_BASE : EVEN_BASE;
  endfunction

  function automatic logic [3:0] mode_tc(input logic mode);
    return mode ? ODD_TC : EVEN_TC;
  endfunction

  // Out-of-range or wrong-parity counts resync to the mode base instead of stepping.
  function automatic logic [3:0] next_eo(input logic [3:0] c, input logic mode);
    logic [3:0] nxt;
    if ((c > BCD_MAX) || (c[0] != mode) || (c == mode_tc(mode))) begin
      nxt = mode_base(mode);
    end else begin
      nxt = c + 4'd2;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_excite.sv
// rtl/sr_excite.sv - per-bit SR excitation from current to target value
module sr_excite (
  input  logic [3:0] cur_i,
  input  logic [3:0] tgt_i,
  output logic [3:0] s_o,
  output logic [3:0] r_o
);

  assign s_o = ~cur_i & tgt_i;
  assign r_o = cur_i & ~tgt_i;

endmodule

// File: rtl/sr_bcd_step_driver.sv
// rtl/sr_bcd_step_driver.sv - sequences external SR flip-flops through even/odd BCD counts
module sr_bcd_step_driver
  import sr_bcd_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             clr_err,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             mismatch
);

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] tgt_q, tgt_d;
  logic       mode_q, mode_d;
  logic [3:0] s_q, s_d;
  logic [3:0] r_q, r_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tc_q, tc_d;
  logic       mismatch_q, mismatch_d;

  logic [3:0] idle_tgt;
  logic [3:0] exc_s;
  logic [3:0] exc_r;

  // Target chosen in IDLE; kept outside the FSM block so excitation has no comb loop.
  assign idle_tgt = load ? ((load_val > BCD_MAX) ? mode_base(mode) : load_val)
                         : next_eo(count_q, mode);

  sr_excite u_excite (
    .cur_i (count_q),
    .tgt_i (idle_tgt),
    .s_o   (exc_s),
    .r_o   (exc_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      tgt_q      <= 4'd0;
      mode_q     <= 1'b0;
      s_q        <= 4'd0;
      r_q        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
      mode_q     <= mode_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tgt_d      = tgt_q;
    mode_d     = mode_q;
    s_d        = 4'd0;
    r_d        = 4'd0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tc_d       = tc_q;
    mismatch_d = clr_err ? 1'b0 : mismatch_q;

    case (state_q)
      IDLE: begin
        if (load || en) begin
          tgt_d   = idle_tgt;
          mode_d  = mode;
          s_d     = exc_s;
          r_d     = exc_r;
          busy_d  = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        state_d = VERIFY;
      end
      VERIFY: begin
        count_d = tgt_q;
        tc_d    = (tgt_q == mode_tc(mode_q));
        // A fresh mismatch overrides a simultaneous clear.
        if (q_fb != tgt_q) begin
          mismatch_d = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign s        = s_q;
  assign r        = r_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc       = tc_q;
  assign mismatch = mismatch_q;

endmodule
